// File: rtl/lsu_unit.sv
// Multi-cycle load/store unit: valid/ready request from execute, variable-latency bus, held response.
// Optional LSU_MISALIGN_SPLIT_EN turns misaligned accesses into two sequential bus accesses.
module lsu_unit #(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OFFW = $clog2(NB)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic [4:0]      resp_rd,
  output logic            resp_wen,
  output logic            resp_err,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [NB-1:0]   mem_wmask,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_REQ2  = 3'd4,
    ST_WAIT2 = 3'd5
  } state_t;

  state_t state_r, state_nxt_s;

  logic            wen_r, err_r, split_r;
  logic [2:0]      funct3_r;
  logic [XLEN-1:0] addr_r, wdata_r, result_r, word0_r;
  logic [4:0]      rd_r;

  logic              legal_s, misal_s, err_s, split_s;
  logic [OFFW-1:0]   off_r_s;
  logic [OFFW+2:0]   sh_s;
  logic [XLEN-1:0]   base_addr_s;
  logic [2*XLEN-1:0] wdata_wide_s;
  logic [2*NB-1:0]   mask_wide_s;

  function automatic logic funct3_legal(input logic wen, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b011:                 ok = (XLEN == 64);
      3'b100, 3'b101:         ok = ~wen;
      3'b110:                 ok = ~wen && (XLEN == 64);
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [NB-1:0] base_mask(input logic [1:0] size);
    logic [NB-1:0] m;
    case (size)
      2'b00:   m = NB'(8'h01);
      2'b01:   m = NB'(8'h03);
      2'b10:   m = NB'(8'h0F);
      2'b11:   m = NB'(8'hFF);
      default: m = NB'(8'h01);
    endcase
    return m;
  endfunction

  // keep = low size bytes, top = their MSB; sign-extend when funct3[2] is clear
  function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] v);
    logic [XLEN-1:0] keep, top, r;
    keep = (XLEN'(1'b1) << (32'd8 << f3[1:0])) - XLEN'(1'b1);
    top  = keep & ~(keep >> 1);
    if (!f3[2] && (|(v & top))) r = v | ~keep;
    else                        r = v & keep;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] shr_pair(input logic [XLEN-1:0] hi, input logic [XLEN-1:0] lo,
                                               input logic [OFFW+2:0] sh);
    logic [2*XLEN-1:0] w;
    w = {hi, lo} >> sh;
    return w[XLEN-1:0];
  endfunction

  assign legal_s = funct3_legal(req_wen, req_funct3);
  assign misal_s = |(req_addr[OFFW-1:0] & OFFW'((32'd1 << req_funct3[1:0]) - 32'd1));

`ifdef LSU_MISALIGN_SPLIT_EN
  assign err_s   = ~legal_s;
  assign split_s = legal_s & misal_s;
`else
  assign err_s   = ~legal_s | misal_s;
  assign split_s = 1'b0;
`endif

  assign off_r_s      = addr_r[OFFW-1:0];
  assign sh_s         = {off_r_s, 3'b000};
  assign base_addr_s  = {addr_r[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign wdata_wide_s = {{XLEN{1'b0}}, wdata_r} << sh_s;
  assign mask_wide_s  = {{NB{1'b0}}, base_mask(funct3_r[1:0])} << off_r_s;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  if (req_valid) state_nxt_s = err_s ? ST_RESP : ST_REQ;
                else           state_nxt_s = ST_IDLE;
      ST_REQ:   if (mem_ready) state_nxt_s = wen_r ? (split_r ? ST_REQ2 : ST_RESP) : ST_WAIT;
                else           state_nxt_s = ST_REQ;
      ST_WAIT:  if (mem_rvalid) state_nxt_s = split_r ? ST_REQ2 : ST_RESP;
                else            state_nxt_s = ST_WAIT;
      ST_REQ2:  if (mem_ready) state_nxt_s = wen_r ? ST_RESP : ST_WAIT2;
                else           state_nxt_s = ST_REQ2;
      ST_WAIT2: if (mem_rvalid) state_nxt_s = ST_RESP;
                else            state_nxt_s = ST_WAIT2;
      ST_RESP:  if (resp_ready) state_nxt_s = ST_IDLE;
                else            state_nxt_s = ST_RESP;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // request latch and load-result capture; result is cleared at acceptance so stores/errors return 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wen_r    <= 1'b0;
      err_r    <= 1'b0;
      split_r  <= 1'b0;
      funct3_r <= 3'b000;
      addr_r   <= '0;
      wdata_r  <= '0;
      rd_r     <= 5'd0;
      result_r <= '0;
      word0_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            wen_r    <= req_wen;
            err_r    <= err_s;
            split_r  <= split_s;
            funct3_r <= req_funct3;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
            rd_r     <= req_rd;
            result_r <= '0;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            if (split_r) word0_r  <= mem_rdata;
            else         result_r <= extend(funct3_r, mem_rdata >> sh_s);
          end
        end
        ST_WAIT2: begin
          if (mem_rvalid) result_r <= extend(funct3_r, shr_pair(mem_rdata, word0_r, sh_s));
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

  // Moore outputs decoded from state and latched fields
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_rd    = 5'd0;
    resp_wen   = 1'b0;
    resp_err   = 1'b0;
    mem_valid  = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;
    case (state_r)
      ST_IDLE: req_ready = 1'b1;
      ST_REQ: begin
        mem_valid = 1'b1;
        mem_wen   = wen_r;
        mem_addr  = base_addr_s;
        mem_wdata = wen_r ? wdata_wide_s[XLEN-1:0] : '0;
        mem_wmask = wen_r ? mask_wide_s[NB-1:0] : '0;
      end
      ST_REQ2: begin
        mem_valid = 1'b1;
        mem_wen   = wen_r;
        mem_addr  = base_addr_s + XLEN'(NB);
        mem_wdata = wen_r ? wdata_wide_s[2*XLEN-1:XLEN] : '0;
        mem_wmask = wen_r ? mask_wide_s[2*NB-1:NB] : '0;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = result_r;
        resp_rd    = rd_r;
        resp_wen   = ~wen_r & ~err_r;
        resp_err   = err_r;
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_lsu_unit.sv
// Directed self-checking bench for lsu_unit (XLEN=32): bus responder and writeback driven from one sequence.
module tb_lsu_unit;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, req_wen, resp_valid, resp_ready, resp_wen, resp_err;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [4:0]  req_rd, resp_rd;
  logic [3:0]  mem_wmask;
  logic [31:0] a0, a1, wd;
  logic [3:0]  wm;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
    .resp_wen(resp_wen), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    int n = 0;
    req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin tick(); n++; end
    chk("req_ready_at_issue", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic serve(input int stall, input logic give_rvalid, input logic [31:0] rdata,
                       output logic [31:0] addr, output logic [31:0] wdata, output logic [3:0] wmask);
    int n = 0;
    while (!mem_valid && n < 20) begin tick(); n++; end
    chk("mem_valid_seen", 32'(mem_valid), 32'd1);
    addr = mem_addr; wdata = mem_wdata; wmask = mem_wmask;
    repeat (stall) begin
      tick();
      chk("mem_addr_stable", mem_addr, addr);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    if (give_rvalid) begin
      mem_rvalid = 1'b1; mem_rdata = rdata;
      tick();
      mem_rvalid = 1'b0; mem_rdata = 32'd0;
    end
  endtask

  task automatic wait_resp();
    int n = 0;
    while (!resp_valid && n < 20) begin tick(); n++; end
    chk("resp_valid_seen", 32'(resp_valid), 32'd1);
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic load_check(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] word, input logic [31:0] exp_addr, input logic [31:0] exp_data);
    issue(1'b0, f3, addr, 32'd0, 5'd2);
    serve(0, 1'b1, word, a0, wd, wm);
    chk({tag, "_addr"}, a0, exp_addr);
    wait_resp();
    chk({tag, "_rdata"}, resp_rdata, exp_data);
    chk({tag, "_wen"}, 32'(resp_wen), 32'd1);
    handshake();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'b000; req_addr = 32'd0;
    req_wdata = 32'd0; req_rd = 5'd0; resp_ready = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 32'd0;
    tick(); tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // lw with two stall cycles
    issue(1'b0, 3'b010, 32'h8000_0004, 32'd0, 5'd5);
    chk("lw_mem_wen", 32'(mem_wen), 32'd0);
    serve(2, 1'b1, 32'hDEAD_BEEF, a0, wd, wm);
    chk("lw_addr", a0, 32'h8000_0004);
    wait_resp();
    chk("lw_rdata", resp_rdata, 32'hDEAD_BEEF);
    chk("lw_wen", 32'(resp_wen), 32'd1);
    chk("lw_err", 32'(resp_err), 32'd0);
    chk("lw_rd", 32'(resp_rd), 32'd5);
    handshake();

    load_check("lb",  3'b000, 32'h8000_0003, 32'h8012_3456, 32'h8000_0000, 32'hFFFF_FF80);
    load_check("lbu", 3'b100, 32'h8000_0003, 32'h8012_3456, 32'h8000_0000, 32'h0000_0080);
    load_check("lh",  3'b001, 32'h8000_0002, 32'h8012_3456, 32'h8000_0000, 32'hFFFF_8012);
    load_check("lhu", 3'b101, 32'h8000_0002, 32'h8012_3456, 32'h8000_0000, 32'h0000_8012);
    load_check("lb0", 3'b000, 32'h8000_0000, 32'h8012_3456, 32'h8000_0000, 32'h0000_0056);

    // sh to upper half
    issue(1'b1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 5'd3);
    chk("sh_mem_wen", 32'(mem_wen), 32'd1);
    serve(0, 1'b0, 32'd0, a0, wd, wm);
    chk("sh_addr", a0, 32'h8000_0000);
    chk("sh_wmask", 32'(wm), 32'h0000_000C);
    chk("sh_wdata", wd, 32'hABCD_0000);
    wait_resp();
    chk("sh_resp_wen", 32'(resp_wen), 32'd0);
    chk("sh_resp_err", 32'(resp_err), 32'd0);
    chk("sh_resp_rdata", resp_rdata, 32'd0);
    handshake();

    // sb to lane 1
    issue(1'b1, 3'b000, 32'h8000_0001, 32'h1234_5678, 5'd3);
    serve(0, 1'b0, 32'd0, a0, wd, wm);
    chk("sb_wmask", 32'(wm), 32'h0000_0002);
    chk("sb_wdata", wd, 32'h3456_7800);
    wait_resp();
    handshake();

    // misaligned lw
    issue(1'b0, 3'b010, 32'h8000_0001, 32'd0, 5'd6);
`ifdef LSU_MISALIGN_SPLIT_EN
    serve(0, 1'b1, 32'h4433_2211, a0, wd, wm);
    serve(0, 1'b1, 32'h8877_6655, a1, wd, wm);
    chk("mis_addr0", a0, 32'h8000_0000);
    chk("mis_addr1", a1, 32'h8000_0004);
    wait_resp();
    chk("mis_rdata", resp_rdata, 32'h5544_3322);
    chk("mis_err", 32'(resp_err), 32'd0);
`else
    chk("mis_no_mem_valid", 32'(mem_valid), 32'd0);
    wait_resp();
    chk("mis_err", 32'(resp_err), 32'd1);
    chk("mis_rdata", resp_rdata, 32'd0);
    chk("mis_wen", 32'(resp_wen), 32'd0);
`endif
    handshake();

    // illegal funct3: ld on RV32, store with funct3 100
    issue(1'b0, 3'b011, 32'h8000_0000, 32'd0, 5'd1);
    chk("ill_ld_mem_valid", 32'(mem_valid), 32'd0);
    wait_resp();
    chk("ill_ld_err", 32'(resp_err), 32'd1);
    chk("ill_ld_wen", 32'(resp_wen), 32'd0);
    handshake();
    issue(1'b1, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1);
    chk("ill_st_mem_valid", 32'(mem_valid), 32'd0);
    wait_resp();
    chk("ill_st_err", 32'(resp_err), 32'd1);
    handshake();

    // response held while writeback stalls; queued request waits for the handshake
    issue(1'b0, 3'b010, 32'h8000_0008, 32'd0, 5'd7);
    serve(0, 1'b1, 32'hCAFE_F00D, a0, wd, wm);
    wait_resp();
    req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_000C; req_rd = 5'd9; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_resp_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, 32'hCAFE_F00D);
      chk("hold_rd", 32'(resp_rd), 32'd7);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    handshake();
    chk("post_hs_req_ready", 32'(req_ready), 32'd1);
    chk("post_hs_mem_valid", 32'(mem_valid), 32'd0);
    tick();
    req_valid = 1'b0;
    chk("next_mem_valid", 32'(mem_valid), 32'd1);
    chk("next_mem_addr", mem_addr, 32'h8000_000C);
    serve(0, 1'b1, 32'h1357_9BDF, a0, wd, wm);
    wait_resp();
    chk("next_rdata", resp_rdata, 32'h1357_9BDF);
    chk("next_rd", 32'(resp_rd), 32'd9);
    handshake();

    // reset while waiting for read data
    issue(1'b0, 3'b010, 32'h8000_0010, 32'd0, 5'd8);
    serve(0, 1'b0, 32'd0, a0, wd, wm);
    chk("wait_mem_valid", 32'(mem_valid), 32'd0);
    rst_n = 1'b0;
    tick();
    chk("rstw_req_ready", 32'(req_ready), 32'd1);
    chk("rstw_mem_valid", 32'(mem_valid), 32'd0);
    chk("rstw_resp_valid", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    load_check("after_rst", 3'b010, 32'h8000_0014, 32'h2468_ACE0, 32'h8000_0014, 32'h2468_ACE0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
- Parametrised multi-cycle load/store unit; the next generation of the execute-stage memory path.
- Replaces combinational one-shot memory calls with a valid/ready request from execute and a variable-latency memory bus.
- Supports all RV32/RV64 integer load/store widths with sign/zero extension and byte masks.
- Returns the GPR writeback result through a held response handshake.

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64.
- NB, XLEN/8, bytes per bus word (derived; not overridden).
- OFFW, $clog2(NB), byte-offset bits within a bus word (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  execute presents an access.
- req_ready  out  1  unit accepts an access (IDLE only).
- req_wen  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (size/sign).
- req_addr  in  XLEN  effective byte address.
- req_wdata  in  XLEN  store data, LSB-aligned.
- req_rd  in  5  destination register for loads.
- resp_valid  out  1  result available.
- resp_ready  in  1  writeback accepts result.
- resp_rdata  out  XLEN  extended load data; 0 for stores/errors.
- resp_rd  out  5  echoed req_rd.
- resp_wen  out  1  GPR write enable: 1 only for successful loads.
- resp_err  out  1  misaligned or illegal access.
- mem_valid  out  1  bus request.
- mem_ready  in  1  bus accepts request.
- mem_wen  out  1  bus write.
- mem_addr  out  XLEN  word-aligned address (low OFFW bits 0).
- mem_wdata  out  XLEN  store data shifted to lane.
- mem_wmask  out  NB  byte-lane write mask.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  XLEN  read data, full word.

Behaviour:
- Reset (rst_n low at posedge): state IDLE; req_ready=1; all other outputs 0. Reset mid-operation abandons any outstanding bus or response transaction immediately; the bus slave tolerates the dropped request.
- FSM states: IDLE -> REQ -> (load: WAIT) -> RESP -> IDLE.
- IDLE: req_ready=1. On req_valid, latch all req_* fields; go to REQ next cycle, or to RESP directly if the access is illegal or misaligned.
- REQ: mem_valid=1 with stable address/data/mask until mem_ready.
  - Store: complete on the handshake, go to RESP.
  - Load: go to WAIT.
  - mem_rvalid in the same cycle as mem_ready is not legal bus behaviour; the earliest rvalid is the cycle after.
- WAIT: capture mem_rdata when mem_rvalid=1, go to RESP.
- RESP: resp_valid=1; outputs held stable until resp_ready; return to IDLE on the handshake. Minimum load latency from acceptance to resp_valid is 3 cycles.
- Lane arithmetic (off = addr[OFFW-1:0]):
  - mem_addr = addr with low OFFW bits cleared.
  - mem_wdata = wdata << (8*off).
  - mem_wmask = base mask << off; base mask is 1, 3, F or FF for byte, half, word and double.
  - Load data = mem_rdata >> (8*off), truncated to size, then sign-extended (funct3 000/001/010/011) or zero-extended (100/101/110).
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101; plus 011 and 110 when XLEN=64.
  - Stores: 000, 001, 010; plus 011 when XLEN=64.
  - Any other value gives resp_err=1 with no bus access.
- Misaligned: half with off[0]≠0, word with off[1:0]≠0, double with off≠0.
- Error response: resp_err=1, resp_wen=0, resp_rdata=0.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Undefined: misaligned access follows the error path above.
- Defined: a misaligned access is split into two sequential bus accesses.
  - First access: word at mem_addr, low lanes.
  - Second access: word at mem_addr+NB, remaining lanes via mask >> (NB-off).
  - Extra states REQ2/WAIT2 follow the same handshake rules as REQ/WAIT.
  - Load data = {word1, word0} >> (8*off), then extended. resp_err=0.
  - Illegal funct3 still errors.

Test Plan:
- lw 0x80000004; mem_ready after 2 stall cycles; rdata 0xDEADBEEF -> mem_addr=0x80000004, resp_rdata=0xDEADBEEF, resp_wen=1, resp_err=0.
- Word 0x80123456 at 0x80000000: lb 0x80000003 -> 0xFFFFFF80; lbu -> 0x00000080; lh 0x80000002 -> 0xFFFF8012.
- sh 0x80000002, wdata 0x0000ABCD -> mem_addr=0x80000000, wmask=4'b1100, wdata[31:16]=0xABCD; resp_wen=0 when resp_valid is asserted.
- lw 0x80000001, words 0x44332211 @0x80000000 and 0x88776655 @0x80000004:
  - Without macro: no mem_valid, resp_err=1, resp_rdata=0.
  - With macro: two bus reads, resp_rdata=0x55443322.
- resp_ready held low 3 cycles after resp_valid -> resp_* stable, req_ready=0; new request accepted only after the handshake.
- rst_n low during WAIT -> next cycle state IDLE, mem_valid=0, resp_valid=0, req_ready=1; a following lw completes normally.
